tpu_tile_sched: RTL and testbench
=================================

TPU_TILE_SCHED -- requirements
Module: tpu_tile_sched

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 16, the width of the buffer base-offset outputs.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, the maximum cycles to wait for core_busy to rise after a launch.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  host job request, sampled only in IDLE.
REQ-006 K  in  8  shared dimension of the host job.
REQ-007 M  in  8  row count of A and C.
REQ-008 N  in  8  column count of B and C.
REQ-009 busy  out  1  job in progress.
REQ-010 done  out  1  one-cycle pulse at job completion.
REQ-011 err  out  1  sticky error flag, cleared by the next accepted start.
REQ-012 core_in_valid  out  1  one-cycle launch pulse to the TPU core.
REQ-013 core_K, core_M, core_N  out  8 each  dimensions presented to the core.
REQ-014 b_base  out  ADDR_BITS  B-buffer base offset for the current N-tile.
REQ-015 c_base  out  ADDR_BITS  C-buffer base offset for the current N-tile.
REQ-016 core_busy  in  1  core busy flag.

Function
REQ-017 The job SHALL be split into N-tiles of 4 columns; tile count T = ceil(N/4) = (N+3)>>2.
REQ-018 States SHALL be IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE, NEXT and FINISH.
REQ-019 In IDLE, start=1 with K, M and N all nonzero and K, M multiples of 4 SHALL latch K, M, N, clear err, set tile=0 and go to LAUNCH; busy SHALL be 1 from the next cycle.
REQ-020 In IDLE, start=1 with an illegal dimension SHALL set err=1, keep busy=0, stay in IDLE and raise no done.
REQ-021 LAUNCH SHALL drive core_in_valid=1 for exactly one cycle, with core_K=K, core_M=M, core_N=4, b_base=tile*K and c_base=tile*M (zero-extended, no overflow for 8-bit operands), then go to WAIT_BUSY.
REQ-022 core_K, core_M, core_N, b_base and c_base SHALL hold stable from LAUNCH until the next LAUNCH or FINISH.
REQ-023 WAIT_BUSY SHALL go to WAIT_IDLE when core_busy=1; after TIMEOUT cycles without core_busy it SHALL set err=1 and go to FINISH.
REQ-024 WAIT_IDLE SHALL go to NEXT on the first cycle core_busy=0.
REQ-025 NEXT SHALL increment tile and go to LAUNCH if tile+1 < T, else go to FINISH.
REQ-026 FINISH SHALL pulse done=1 for one cycle, drop busy the same cycle, and return to IDLE.
REQ-027 The launch-to-launch gap SHALL be at least 4 cycles (LAUNCH, WAIT_BUSY, WAIT_IDLE, NEXT).
REQ-028 start asserted outside IDLE SHALL be ignored and SHALL NOT alter latched dimensions.
REQ-029 Latency from accepted start to the first core_in_valid SHALL be 1 cycle.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, tile=0, and busy, done, err and core_in_valid to 0, with core_K/M/N, b_base and c_base at 0.
REQ-031 Reset asserted mid-job SHALL abort without a done pulse; the first start after reset release SHALL be accepted normally.

Verification
REQ-032 K=8, M=4, N=16, core busy 5 cycles per launch -> 4 launches with b_base 0, 8, 16, 24, c_base 0, 4, 8, 12; one done; err=0.
REQ-033 N=6 -> T=2, two launches with core_N=4 each, then done.
REQ-034 K=6 -> err=1, busy stays 0, no core_in_valid, no done.
REQ-035 Core never raises busy -> err=1 and done exactly TIMEOUT+2 cycles after launch; busy then 0.
REQ-036 start pulsed during WAIT_IDLE with different K -> ignored; remaining launches use the original K.
REQ-037 rst_n low during the second tile of a 4-tile job -> outputs 0 asynchronously, no done; a new K=4, M=4, N=4 job completes with one launch.

Source files
------------

// File: rtl/tpu_tile_sched.sv
// Host-job scheduler for a TPU core: splits a K x M x N job into 4-column N-tiles
// and launches the core once per tile, tracking busy handshakes and a launch timeout.
module tpu_tile_sched #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           K,
    input  logic [7:0]           M,
    input  logic [7:0]           N,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 core_in_valid,
    output logic [7:0]           core_K,
    output logic [7:0]           core_M,
    output logic [7:0]           core_N,
    output logic [ADDR_BITS-1:0] b_base,
    output logic [ADDR_BITS-1:0] c_base,
    input  logic                 core_busy
);

    localparam int unsigned CW = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_IDLE,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             k_q, k_d;
    logic [7:0]             m_q, m_d;
    logic [7:0]             n_q, n_d;
    logic [6:0]             tiles_q, tiles_d;
    logic [6:0]             tile_q, tile_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [ADDR_BITS-1:0]   b_base_q, b_base_d;
    logic [ADDR_BITS-1:0]   c_base_q, c_base_d;
    logic                   legal;

    assign legal = (K != 8'd0) && (M != 8'd0) && (N != 8'd0) &&
                   (K[1:0] == 2'b00) && (M[1:0] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            m_q      <= '0;
            n_q      <= '0;
            tiles_q  <= '0;
            tile_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            b_base_q <= '0;
            c_base_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            m_q      <= m_d;
            n_q      <= n_d;
            tiles_q  <= tiles_d;
            tile_q   <= tile_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            b_base_q <= b_base_d;
            c_base_q <= c_base_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        m_d      = m_q;
        n_d      = n_q;
        tiles_d  = tiles_q;
        tile_d   = tile_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        b_base_d = b_base_q;
        c_base_d = c_base_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (legal) begin
                        k_d      = K;
                        m_d      = M;
                        n_d      = 8'd4;
                        tiles_d  = 7'(({1'b0, N} + 9'd3) >> 2);
                        tile_d   = '0;
                        b_base_d = '0;
                        c_base_d = '0;
                        err_d    = 1'b0;
                        state_d  = S_LAUNCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (core_busy) begin
                    state_d = S_WAIT_IDLE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (!core_busy) state_d = S_NEXT;
            end
            S_NEXT: begin
                // Bases advance by K/M per tile, so they always equal tile*K and tile*M.
                if ((tile_q + 7'd1) < tiles_q) begin
                    tile_d   = tile_q + 7'd1;
                    b_base_d = b_base_q + ADDR_BITS'(k_q);
                    c_base_d = c_base_q + ADDR_BITS'(m_q);
                    state_d  = S_LAUNCH;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy          = (state_q == S_LAUNCH) || (state_q == S_WAIT_BUSY) ||
                           (state_q == S_WAIT_IDLE) || (state_q == S_NEXT);
    assign done          = (state_q == S_FINISH);
    assign core_in_valid = (state_q == S_LAUNCH);
    assign err           = err_q;
    assign core_K        = k_q;
    assign core_M        = m_q;
    assign core_N        = n_q;
    assign b_base        = b_base_q;
    assign c_base        = c_base_q;

endmodule

// File: tb/tb_tpu_tile_sched.sv
// Scoreboard bench for tpu_tile_sched: a behavioural core answers launches, and every
// expected launch descriptor is queued at job issue and checked when the launch appears.
module tb_tpu_tile_sched;

    localparam int unsigned AB = 16;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [7:0]    K, M, N;
    logic          core_busy;
    logic          busy, done, err, core_in_valid;
    logic [7:0]    core_K, core_M, core_N;
    logic [AB-1:0] b_base, c_base;

    typedef struct {
        logic [7:0]    k;
        logic [7:0]    m;
        logic [7:0]    n;
        logic [AB-1:0] b;
        logic [AB-1:0] c;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_launch = 0;
    int n_done   = 0;
    int last_launch_cyc = 0;
    int prev_launch_cyc = 0;
    int done_cyc = 0;
    int busy_len = 5;
    bit core_never = 1'b0;
    int core_cnt = 0;

    tpu_tile_sched #(.ADDR_BITS(AB), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .K             (K),
        .M             (M),
        .N             (N),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .core_in_valid (core_in_valid),
        .core_K        (core_K),
        .core_M        (core_M),
        .core_N        (core_N),
        .b_base        (b_base),
        .c_base        (c_base),
        .core_busy     (core_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: busy rises the cycle after a launch and stays high busy_len cycles.
    initial begin
        core_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                core_cnt  = 0;
                core_busy = 1'b0;
            end else begin
                core_busy = (core_cnt > 0);
                if (core_cnt > 0) core_cnt--;
                if (core_in_valid === 1'b1 && !core_never) core_cnt = busy_len;
            end
        end
    end

    // Monitor: pops the scoreboard on every launch and records done pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (core_in_valid === 1'b1) begin
                    prev_launch_cyc = last_launch_cyc;
                    last_launch_cyc = cyc;
                    n_launch++;
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL launch_unexpected: got launch K=%0d M=%0d N=%0d b=%0d c=%0d, required none",
                                 core_K, core_M, core_N, b_base, c_base);
                    end else begin
                        e = exp_q.pop_front();
                        if ({core_K, core_M, core_N, b_base, c_base} !== {e.k, e.m, e.n, e.b, e.c}) begin
                            bad++;
                            $display("FAIL launch_desc: got K=%0d M=%0d N=%0d b=%0d c=%0d, required K=%0d M=%0d N=%0d b=%0d c=%0d",
                                     core_K, core_M, core_N, b_base, c_base, e.k, e.m, e.n, e.b, e.c);
                        end
                    end
                end
                if (done === 1'b1) begin
                    n_done++;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_job(input int k, input int m, input int n);
        exp_t x;
        int t_cnt;
        t_cnt = (n + 3) / 4;
        for (int t = 0; t < t_cnt; t++) begin
            x.k = 8'(k);
            x.m = 8'(m);
            x.n = 8'd4;
            x.b = AB'(t * k);
            x.c = AB'(t * m);
            exp_q.push_back(x);
        end
    endtask

    task automatic start_job(input int k, input int m, input int n);
        tick();
        K = 8'(k);
        M = 8'(m);
        N = 8'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        d0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_done != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        K = '0; M = '0; N = '0;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        total++;
        if ({busy, done, err, core_in_valid} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got busy/done/err/civ=%b, required 0000", {busy, done, err, core_in_valid});
        end
        total++;
        if ({core_K, core_M, core_N} !== 24'd0) begin
            bad++;
            $display("FAIL reset_dims: got K=%0d M=%0d N=%0d, required 0", core_K, core_M, core_N);
        end
        total++;
        if ({b_base, c_base} !== '0) begin
            bad++;
            $display("FAIL reset_bases: got b=%0d c=%0d, required 0", b_base, c_base);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int l0, d0;
        bit ok;
        busy_len = 5;
        l0 = n_launch;
        d0 = n_done;
        push_job(8, 4, 16);
        start_job(8, 4, 16);
        total++;
        if ({busy, core_in_valid, err} !== 3'b110) begin
            bad++;
            $display("FAIL basic_first_launch: got busy/civ/err=%b, required 110", {busy, core_in_valid, err});
        end
        wait_done(200, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_done_timeout: got no done within 200 cycles, required done");
        end
        total++;
        if ({done, busy, err} !== 3'b100) begin
            bad++;
            $display("FAIL basic_finish_flags: got done/busy/err=%b, required 100", {done, busy, err});
        end
        repeat (3) tick();
        total++;
        if (n_launch - l0 != 4 || n_done - d0 != 1) begin
            bad++;
            $display("FAIL basic_counts: got launches=%0d dones=%0d, required 4 and 1", n_launch - l0, n_done - d0);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_drain: got %0d pending launches, required 0", exp_q.size());
        end
    endtask

    task automatic test_partial_tile();
        int l0;
        bit ok;
        busy_len = 3;
        l0 = n_launch;
        push_job(8, 8, 6);
        start_job(8, 8, 6);
        wait_done(100, ok);
        total++;
        if (!ok || n_launch - l0 != 2 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL partial_tile: got done=%0b launches=%0d pending=%0d, required 1 2 0",
                     ok, n_launch - l0, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int l0;
        bit ok;
        busy_len = 1;
        l0 = n_launch;
        push_job(4, 4, 12);
        start_job(4, 4, 12);
        wait_done(100, ok);
        total++;
        if (!ok || n_launch - l0 != 3) begin
            bad++;
            $display("FAIL b2b_count: got done=%0b launches=%0d, required 1 3", ok, n_launch - l0);
        end
        total++;
        if (last_launch_cyc - prev_launch_cyc != 4) begin
            bad++;
            $display("FAIL b2b_gap: got gap=%0d, required 4", last_launch_cyc - prev_launch_cyc);
        end
        busy_len = 5;
    endtask

    task automatic test_illegal();
        logic [7:0] tbl [5][3];
        int l0, d0;
        bit ok;
        tbl[0] = '{8'd6, 8'd4, 8'd4};
        tbl[1] = '{8'd4, 8'd6, 8'd4};
        tbl[2] = '{8'd0, 8'd4, 8'd4};
        tbl[3] = '{8'd4, 8'd0, 8'd4};
        tbl[4] = '{8'd4, 8'd4, 8'd0};
        l0 = n_launch;
        d0 = n_done;
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL illegal_pre_err: got err=%b, required 0", err);
        end
        for (int i = 0; i < 5; i++) begin
            start_job(tbl[i][0], tbl[i][1], tbl[i][2]);
            repeat (2) tick();
            total++;
            if ({err, busy, core_in_valid, done} !== 4'b1000) begin
                bad++;
                $display("FAIL illegal_%0d: got err/busy/civ/done=%b, required 1000", i, {err, busy, core_in_valid, done});
            end
        end
        total++;
        if (n_launch != l0 || n_done != d0) begin
            bad++;
            $display("FAIL illegal_activity: got launches=%0d dones=%0d, required 0 0", n_launch - l0, n_done - d0);
        end
        push_job(4, 4, 4);
        start_job(4, 4, 4);
        total++;
        if ({err, busy} !== 2'b01) begin
            bad++;
            $display("FAIL illegal_err_clear: got err/busy=%b, required 01", {err, busy});
        end
        wait_done(100, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL illegal_recover_done: got no done, required done");
        end
    endtask

    task automatic test_timeout();
        bit ok;
        core_never = 1'b1;
        push_job(4, 4, 4);
        start_job(4, 4, 4);
        wait_done(TO + 20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL timeout_no_done: got no done within %0d cycles, required done", TO + 20);
        end
        total++;
        if (done_cyc - last_launch_cyc != int'(TO) + 2) begin
            bad++;
            $display("FAIL timeout_latency: got %0d cycles, required %0d", done_cyc - last_launch_cyc, TO + 2);
        end
        total++;
        if ({err, busy} !== 2'b10) begin
            bad++;
            $display("FAIL timeout_flags: got err/busy=%b, required 10", {err, busy});
        end
        tick();
        total++;
        if ({err, busy, done} !== 3'b100) begin
            bad++;
            $display("FAIL timeout_sticky: got err/busy/done=%b, required 100", {err, busy, done});
        end
        core_never = 1'b0;
    endtask

    task automatic test_ignore_start();
        int l0, d0;
        bit ok;
        busy_len = 5;
        l0 = n_launch;
        d0 = n_done;
        push_job(8, 8, 12);
        start_job(8, 8, 12);
        repeat (2) tick();
        K = 8'd12;
        M = 8'd12;
        N = 8'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({busy, err} !== 2'b10) begin
            bad++;
            $display("FAIL ignore_flags: got busy/err=%b, required 10", {busy, err});
        end
        wait_done(200, ok);
        repeat (4) tick();
        total++;
        if (!ok || n_launch - l0 != 3 || n_done - d0 != 1) begin
            bad++;
            $display("FAIL ignore_counts: got done=%0b launches=%0d dones=%0d, required 1 3 1",
                     ok, n_launch - l0, n_done - d0);
        end
    endtask

    task automatic test_reset_mid();
        int l0, d0;
        bit ok;
        bit reached;
        busy_len = 5;
        l0 = n_launch;
        push_job(8, 8, 16);
        start_job(8, 8, 16);
        reached = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (n_launch - l0 >= 2) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        total++;
        if (!reached) begin
            bad++;
            $display("FAIL rstmid_second_tile: got %0d launches, required 2", n_launch - l0);
        end
        d0 = n_done;
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, err, core_in_valid} !== 4'b0000 || {core_K, core_M, core_N, b_base, c_base} !== '0) begin
            bad++;
            $display("FAIL rstmid_async: got busy/done/err/civ=%b K=%0d M=%0d N=%0d b=%0d c=%0d, required all 0",
                     {busy, done, err, core_in_valid}, core_K, core_M, core_N, b_base, c_base);
        end
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        total++;
        if (n_done != d0) begin
            bad++;
            $display("FAIL rstmid_no_done: got %0d dones, required 0", n_done - d0);
        end
        l0 = n_launch;
        d0 = n_done;
        push_job(4, 4, 4);
        start_job(4, 4, 4);
        wait_done(100, ok);
        total++;
        if (!ok || n_launch - l0 != 1 || n_done - d0 != 1) begin
            bad++;
            $display("FAIL rstmid_restart: got done=%0b launches=%0d dones=%0d, required 1 1 1",
                     ok, n_launch - l0, n_done - d0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial_tile();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_ignore_start();
        test_reset_mid();
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
